snoop_bus_arbiter: RTL

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_pkg.sv | 37 +++
 rtl/snoop_bus_arbiter_if.sv | 44 ++++
 rtl/snoop_bus_arbiter_rr_arbiter.sv | 35 +++
 rtl/snoop_bus_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// ============================================================================
// Module   : snoop_bus_pkg
// Brief    : Shared FSM states, request-type encodings and core-count default
//            for the snoop bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADDRESSSIZE
`define ADDRESSSIZE 32
`endif

package snoop_bus_pkg;

  localparam int NUM_CORES_DEF = 4;

  localparam logic [1:0] REQ_RSVD   = 2'b00;
  localparam logic [1:0] REQ_BUSRD  = 2'b01;
  localparam logic [1:0] REQ_BUSRDX = 2'b10;
  localparam logic [1:0] REQ_INV    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_SNOOP = 3'd2,
    ST_MEM   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The reserved encoding is serviced as an ordinary read.
  function automatic logic [1:0] norm_type(input logic [1:0] t);
    return (t == REQ_RSVD) ? REQ_BUSRD : t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snoop_bus_arbiter_if.sv
// ============================================================================
// Module   : snoop_bus_arbiter_if
// Brief    : Request, snoop and memory handshake bundle of the snoop bus.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADDRESSSIZE
`define ADDRESSSIZE 32
`endif

interface snoop_bus_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = `ADDRESSSIZE
);
  logic [NUM_CORES-1:0]        req;
  logic [2*NUM_CORES-1:0]      req_type;
  logic [NUM_CORES*ADDR_W-1:0] req_addr;
  logic [NUM_CORES-1:0]        snoop_hit;
  logic                        mem_ack;
  logic [NUM_CORES-1:0]        grant;
  logic [NUM_CORES-1:0]        done;
  logic                        BusRd;
  logic                        BusRdX;
  logic                        Invalidate;
  logic [ADDR_W-1:0]           Address_Com;
  logic                        Shared;
  logic                        mem_rd_req;
  logic                        bus_err;

  modport master (
    output req, req_type, req_addr, snoop_hit, mem_ack,
    input  grant, done, BusRd, BusRdX, Invalidate, Address_Com, Shared,
           mem_rd_req, bus_err
  );

  modport slave (
    input  req, req_type, req_addr, snoop_hit, mem_ack,
    output grant, done, BusRd, BusRdX, Invalidate, Address_Com, Shared,
           mem_rd_req, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick; search starts one past last winner.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic [NUM_CORES-1:0] o_winner
);

  int   w_idx;
  logic w_found;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      w_idx = (int'(i_last) + i) % NUM_CORES;
      if (!w_found && i_req[w_idx]) begin
        o_winner[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/snoop_bus_arbiter.sv
// ============================================================================
// Module   : snoop_bus_arbiter
// Brief    : Round-robin snoop bus arbiter sequencing GRANT/SNOOP/MEM/DONE.
//            Optional memory-ack timeout enabled by SNOOP_BUS_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ADDRESSSIZE
`define ADDRESSSIZE 32
`endif

module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W    = `ADDRESSSIZE,
  parameter int TO_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  snoop_bus_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_t               r_state;
  state_t               w_next;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     r_win;
  logic [1:0]           r_type;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_shared;
  logic [NUM_CORES-1:0] w_pick;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [NUM_CORES-1:0] w_win_oh;
  logic                 w_timeout;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_winner (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_pick[i]) w_pick_idx = IDX_W'(i);
    end
  end

  assign w_win_oh = NUM_CORES'(1) << r_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (|bus.req) w_next = ST_GRANT;
      ST_GRANT: w_next = ST_SNOOP;
      ST_SNOOP: w_next = (r_type == REQ_INV) ? ST_DONE : ST_MEM;
      ST_MEM:   if (bus.mem_ack || w_timeout) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last   <= IDX_W'(NUM_CORES - 1);
      r_win    <= '0;
      r_type   <= REQ_BUSRD;
      r_addr   <= '0;
      r_shared <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (|bus.req) begin
          r_win  <= w_pick_idx;
          r_type <= norm_type(bus.req_type[2*int'(w_pick_idx) +: 2]);
          r_addr <= bus.req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
        end
        // The requester's own hit never counts towards Shared.
        ST_SNOOP: r_shared <= |(bus.snoop_hit & ~w_win_oh);
        ST_DONE: begin
          r_last   <= r_win;
          r_shared <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant       = (r_state != ST_IDLE) ? w_win_oh : '0;
  assign bus.done        = (r_state == ST_DONE) ? w_win_oh : '0;
  assign bus.BusRd       = (r_state == ST_SNOOP) && (r_type == REQ_BUSRD);
  assign bus.BusRdX      = (r_state == ST_SNOOP) && (r_type == REQ_BUSRDX);
  assign bus.Invalidate  = (r_state == ST_SNOOP) && (r_type == REQ_INV);
  assign bus.Address_Com = (r_state == ST_SNOOP) ? r_addr : '0;
  assign bus.Shared      = r_shared;
  assign bus.mem_rd_req  = (r_state == ST_MEM);

`ifdef SNOOP_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_bus_err;

  assign w_timeout = (r_state == ST_MEM) && !bus.mem_ack &&
                     (r_to_cnt == TO_W'(TO_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == ST_MEM) r_to_cnt <= r_to_cnt + 1'b1;
      else                   r_to_cnt <= '0;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  assign bus.bus_err = r_bus_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TO_CYCLES != 0);
  assign w_timeout   = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

endmodule

`default_nettype wire
